simon_display_scheduler: RTL

//  Owns the single 3-bit colour display of the Simon game and schedules it between two requesters:

---
 rtl/simon_pkg.sv | 40 ++++
 rtl/simon_tick_timer.sv | 30 +++
 rtl/simon_display_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared constants and helpers for the Simon display scheduler
// Purpose: colour codes, difficulty encodings, default periods, FSM state codes,
//          and small colour helper functions used by the scheduler.
// Ports: none (package).
package simon_pkg;

  localparam int MAX_LEN    = 10;
  localparam int TIMER_W    = 28;
  localparam int T_EASY     = 50_000_000;
  localparam int T_MED      = 25_000_000;
  localparam int T_HARD     = 12_500_000;
  localparam int T_INSANE   = 5_000_000;
  localparam int ECHO_TICKS = 12_500_000;

  localparam logic [2:0] COL_OFF    = 3'd0;
  localparam logic [2:0] COL_RED    = 3'd1;
  localparam logic [2:0] COL_BLUE   = 3'd2;
  localparam logic [2:0] COL_YELLOW = 3'd3;
  localparam logic [2:0] COL_GREEN  = 3'd4;

  localparam logic [1:0] DIFF_EASY   = 2'b00;
  localparam logic [1:0] DIFF_MED    = 2'b01;
  localparam logic [1:0] DIFF_HARD   = 2'b10;
  localparam logic [1:0] DIFF_INSANE = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_ECHO = 2'd3;

  // Pattern steps store a 2-bit code; the visible colour is one higher so 0 stays "off".
  function automatic logic [2:0] code_to_colour(input logic [1:0] code);
    return {1'b0, code} + 3'd1;
  endfunction

  function automatic logic echo_colour_valid(input logic [2:0] c);
    return (c >= COL_RED) && (c <= COL_GREEN);
  endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// rtl/simon_tick_timer.sv - clear/enable tick counter with terminal-count flag
// Purpose: counts cycles spent in the current scheduler state.
// Ports: clk, rst (async active-low), clr (zero count, wins over en), en (count up),
//        limit (period in cycles), expire (high while count == limit-1).
module simon_tick_timer #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == (limit - 1'b1));

endmodule

// File: rtl/simon_display_scheduler.sv
// rtl/simon_display_scheduler.sv - arbitrates the Simon colour display between playback and echo
// Purpose: plays a stored colour pattern with per-difficulty on/off timing, or flashes the
//          player's guess colour; playback has priority, abort cancels everything.
// Ports: clk, rst (async active-low); play_req, pattern, play_len, difficulty (playback request);
//        echo_req, echo_color (guess echo request); abort;
//        display (colour, 0 = off), step_idx (1-based step, 0 idle), play_busy, echo_busy,
//        play_done (one-cycle completion pulse). All outputs are registered.
module simon_display_scheduler
  import simon_pkg::*;
#(
  parameter int MAX_LEN    = simon_pkg::MAX_LEN,
  parameter int TIMER_W    = simon_pkg::TIMER_W,
  parameter int T_EASY     = simon_pkg::T_EASY,
  parameter int T_MED      = simon_pkg::T_MED,
  parameter int T_HARD     = simon_pkg::T_HARD,
  parameter int T_INSANE   = simon_pkg::T_INSANE,
  parameter int ECHO_TICKS = simon_pkg::ECHO_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play_req,
  input  logic [2*MAX_LEN-1:0] pattern,
  input  logic [3:0]           play_len,
  input  logic [1:0]           difficulty,
  input  logic                 echo_req,
  input  logic [2:0]           echo_color,
  input  logic                 abort,
  output logic [2:0]           display,
  output logic [3:0]           step_idx,
  output logic                 play_busy,
  output logic                 echo_busy,
  output logic                 play_done
);

  localparam logic [TIMER_W-1:0] P_EASY   = TIMER_W'(T_EASY);
  localparam logic [TIMER_W-1:0] P_MED    = TIMER_W'(T_MED);
  localparam logic [TIMER_W-1:0] P_HARD   = TIMER_W'(T_HARD);
  localparam logic [TIMER_W-1:0] P_INSANE = TIMER_W'(T_INSANE);
  localparam logic [TIMER_W-1:0] P_ECHO   = TIMER_W'(ECHO_TICKS);

  logic [1:0]           state, state_n;
  logic [2:0]           display_n;
  logic [3:0]           step_n;
  logic                 done_n;
  logic                 pending, pending_n;
  logic [2*MAX_LEN-1:0] pat_q, pat_n;
  logic [3:0]           len_q, len_n;
  logic [TIMER_W-1:0]   per_q, per_n;

  logic [TIMER_W-1:0]   per_in;
  logic [2*MAX_LEN-1:0] src_pat;
  logic [3:0]           src_len;
  logic [TIMER_W-1:0]   src_per;
  logic                 start;
  logic                 expire;
  logic                 tmr_clr;
  logic [TIMER_W-1:0]   tmr_limit;

  always_comb begin
    case (difficulty)
      DIFF_EASY: per_in = P_EASY;
      DIFF_MED:  per_in = P_MED;
      DIFF_HARD: per_in = P_HARD;
      default:   per_in = P_INSANE;
    endcase
  end

  // A request deferred during echo was latched then; otherwise the live inputs are used.
  assign src_pat = pending ? pat_q : pattern;
  assign src_len = pending ? len_q : play_len;
  assign src_per = pending ? per_q : per_in;

  always_comb begin
    state_n   = state;
    display_n = display;
    step_n    = step_idx;
    done_n    = 1'b0;
    pending_n = pending;
    pat_n     = pat_q;
    len_n     = len_q;
    per_n     = per_q;
    start     = 1'b0;

    if (abort) begin
      state_n   = ST_IDLE;
      display_n = COL_OFF;
      step_n    = 4'd0;
      pending_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play_req) begin
            start = 1'b1;
          end else if (echo_req && echo_colour_valid(echo_color)) begin
            state_n   = ST_ECHO;
            display_n = echo_color;
          end
        end
        ST_ON: begin
          if (expire) begin
            state_n   = ST_OFF;
            display_n = COL_OFF;
          end
        end
        ST_OFF: begin
          if (expire) begin
            if (step_idx < len_q) begin
              state_n   = ST_ON;
              // step_idx is 1-based, so it already indexes the next 0-based step.
              display_n = code_to_colour(pat_q[{step_idx, 1'b0} +: 2]);
              step_n    = step_idx + 4'd1;
            end else begin
              state_n = ST_IDLE;
              step_n  = 4'd0;
              done_n  = 1'b1;
            end
          end
        end
        default: begin // ST_ECHO
          if (expire) begin
            display_n = COL_OFF;
            state_n   = ST_IDLE;
            if (pending || play_req) begin
              start = 1'b1;
            end
          end else if (play_req && !pending) begin
            pending_n = 1'b1;
            pat_n     = pattern;
            len_n     = play_len;
            per_n     = per_in;
          end
        end
      endcase

      if (start) begin
        pending_n = 1'b0;
        pat_n     = src_pat;
        len_n     = src_len;
        per_n     = src_per;
        if ((src_len != 4'd0) && (src_len <= 4'(MAX_LEN))) begin
          state_n   = ST_ON;
          display_n = code_to_colour(src_pat[1:0]);
          step_n    = 4'd1;
        end else begin
          state_n   = ST_IDLE;
          display_n = COL_OFF;
          done_n    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      display   <= COL_OFF;
      step_idx  <= 4'd0;
      play_busy <= 1'b0;
      echo_busy <= 1'b0;
      play_done <= 1'b0;
      pending   <= 1'b0;
      pat_q     <= '0;
      len_q     <= 4'd0;
      per_q     <= '0;
    end else begin
      state     <= state_n;
      display   <= display_n;
      step_idx  <= step_n;
      play_busy <= (state_n == ST_ON) || (state_n == ST_OFF);
      echo_busy <= (state_n == ST_ECHO);
      play_done <= done_n;
      pending   <= pending_n;
      pat_q     <= pat_n;
      len_q     <= len_n;
      per_q     <= per_n;
    end
  end

  // Every state entry restarts the timer; idle keeps it parked at zero.
  assign tmr_clr   = (state_n != state) || (state == ST_IDLE);
  assign tmr_limit = (state == ST_ECHO) ? P_ECHO : per_q;

  simon_tick_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (state != ST_IDLE),
    .limit  (tmr_limit),
    .expire (expire)
  );

endmodule
